// File: rtl/display_pkg.sv
// Shared display geometry, tile-map command opcodes and writer FSM states.
package display_pkg;

  localparam int DEFAULT_TILES_PER_LINE = 100;
  localparam int DEFAULT_TILES_PER_COL  = 60;

  // Character index and word counter widths for the default 100x60 map.
  localparam int IDX_WIDTH  = 13;
  localparam int WORD_WIDTH = 11;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_FILL_ROW = 2'b01,
    OP_FILL_ALL = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    FILL  = 2'b10
  } state_e;

endpackage

// File: rtl/tile_lane_encoder.sv
// Maps a character index and tile to a word address, one-hot byte lane and
// lane-shifted write data (write-side dual of the read lane select).
module tile_lane_encoder
  import display_pkg::*;
(
  input  logic [IDX_WIDTH-1:0]  char_idx,
  input  logic [7:0]            tile,
  output logic [WORD_WIDTH-1:0] word,
  output logic [3:0]            byteenable,
  output logic [31:0]           writedata
);

  assign word = char_idx[IDX_WIDTH-1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byteenable[gi]        = (char_idx[1:0] == 2'(gi));
      assign writedata[8*gi +: 8]  = (char_idx[1:0] == 2'(gi)) ? tile : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/tile_map_writer.sv
// Turns single-tile, row-fill and screen-fill commands into byte-enabled
// 32-bit writes to the tile-index RAM, honouring waitrequest.
module tile_map_writer
  import display_pkg::*;
#(
  parameter int          TILES_PER_LINE = DEFAULT_TILES_PER_LINE,
  parameter int          TILES_PER_COL  = DEFAULT_TILES_PER_COL,
  parameter int          ADDR_WIDTH     = 30,
  parameter int unsigned BASE_WORD      = 0
) (
  input  logic                  iCLK_50,
  input  logic                  iRST,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [6:0]            i_cmd_x,
  input  logic [5:0]            i_cmd_y,
  input  logic [7:0]            i_cmd_tile,
  output logic [ADDR_WIDTH-1:0] o_tiles_idx_addr,
  output logic                  o_tiles_idx_write,
  output logic [31:0]           o_tiles_idx_writedata,
  output logic [3:0]            o_tiles_idx_byteenable,
  input  logic                  i_tiles_idx_waitrequest,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [IDX_WIDTH-1:0]  TPL_IDX  = IDX_WIDTH'(TILES_PER_LINE);
  localparam logic [WORD_WIDTH-1:0] WPL      = WORD_WIDTH'(TILES_PER_LINE / 4);
  localparam logic [WORD_WIDTH-1:0] LAST_ALL = WORD_WIDTH'(TILES_PER_LINE * TILES_PER_COL / 4 - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_WORD);

  state_e                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    write_reg, write_next;
  logic [31:0]             data_reg, data_next;
  logic [3:0]              be_reg, be_next;
  logic                    err_reg, err_next;
  logic [WORD_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [WORD_WIDTH-1:0]   last_reg, last_next;

  logic [IDX_WIDTH-1:0]    char_idx;
  logic [WORD_WIDTH-1:0]   enc_word;
  logic [3:0]              enc_be;
  logic [31:0]             enc_data;
  logic [WORD_WIDTH-1:0]   row_start;
  logic                    x_ok, y_ok, accept, done;

  assign char_idx  = IDX_WIDTH'(i_cmd_x) + IDX_WIDTH'(i_cmd_y) * TPL_IDX;
  assign row_start = WORD_WIDTH'(i_cmd_y) * WPL;
  assign x_ok      = int'(i_cmd_x) < TILES_PER_LINE;
  assign y_ok      = int'(i_cmd_y) < TILES_PER_COL;

  tile_lane_encoder u_encoder (
    .char_idx   (char_idx),
    .tile       (i_cmd_tile),
    .word       (enc_word),
    .byteenable (enc_be),
    .writedata  (enc_data)
  );

  assign o_cmd_ready = (state_reg == IDLE) && !iRST;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign done        = write_reg && !i_tiles_idx_waitrequest;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    data_next  = data_reg;
    be_next    = be_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (i_cmd_op)
            OP_WRITE: begin
              if (x_ok && y_ok) begin
                addr_next  = BASE + ADDR_WIDTH'(enc_word);
                data_next  = enc_data;
                be_next    = enc_be;
                write_next = 1'b1;
                state_next = WRITE;
              end else begin
                err_next = 1'b1;
              end
            end
            OP_FILL_ROW: begin
              if (y_ok) begin
                cnt_next   = row_start;
                last_next  = row_start + WPL - WORD_WIDTH'(1);
                addr_next  = BASE + ADDR_WIDTH'(row_start);
                data_next  = {4{i_cmd_tile}};
                be_next    = 4'hF;
                write_next = 1'b1;
                state_next = FILL;
              end else begin
                err_next = 1'b1;
              end
            end
            OP_FILL_ALL: begin
              cnt_next   = '0;
              last_next  = LAST_ALL;
              addr_next  = BASE;
              data_next  = {4{i_cmd_tile}};
              be_next    = 4'hF;
              write_next = 1'b1;
              state_next = FILL;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      WRITE: begin
        if (done) begin
          write_next = 1'b0;
          state_next = IDLE;
        end
      end
      FILL: begin
        // Address steps only on a completed write, so a stall holds everything.
        if (done) begin
          if (cnt_reg == last_reg) begin
            write_next = 1'b0;
            state_next = IDLE;
          end else begin
            cnt_next  = cnt_reg + WORD_WIDTH'(1);
            addr_next = BASE + ADDR_WIDTH'(cnt_reg + WORD_WIDTH'(1));
          end
        end
      end
      default: begin
        write_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      data_reg  <= '0;
      be_reg    <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      data_reg  <= data_next;
      be_reg    <= be_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  assign o_tiles_idx_addr       = addr_reg;
  assign o_tiles_idx_write      = write_reg;
  assign o_tiles_idx_writedata  = data_reg;
  assign o_tiles_idx_byteenable = be_reg;
  assign o_busy                 = (state_reg != IDLE);
  assign o_err                  = err_reg;

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer: single writes, fills, stalls, errors
// and reset during a fill, each scenario checked against hand-derived values.
module tb_tile_map_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [7:0]  cmd_tile = '0;
  logic [29:0] ram_addr;
  logic        ram_write;
  logic [31:0] ram_data;
  logic [3:0]  ram_be;
  logic        ram_wait = 1'b0;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [29:0] comp_addr[$];
  logic [31:0] comp_data[$];
  logic [3:0]  comp_be[$];

  always #10 clk = ~clk;

  tile_map_writer dut (
    .iCLK_50                 (clk),
    .iRST                    (rst),
    .i_cmd_valid             (cmd_valid),
    .o_cmd_ready             (cmd_ready),
    .i_cmd_op                (cmd_op),
    .i_cmd_x                 (cmd_x),
    .i_cmd_y                 (cmd_y),
    .i_cmd_tile              (cmd_tile),
    .o_tiles_idx_addr        (ram_addr),
    .o_tiles_idx_write       (ram_write),
    .o_tiles_idx_writedata   (ram_data),
    .o_tiles_idx_byteenable  (ram_be),
    .i_tiles_idx_waitrequest (ram_wait),
    .o_busy                  (busy),
    .o_err                   (err)
  );

  // Records every completed RAM write.
  always @(posedge clk) begin
    if (!rst && ram_write && !ram_wait) begin
      comp_addr.push_back(ram_addr);
      comp_data.push_back(ram_data);
      comp_be.push_back(ram_be);
    end
  end

  task automatic send(input logic [1:0] op, input logic [6:0] x, input logic [5:0] y,
                      input logic [7:0] t);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_tile = t;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_write, ram_addr, ram_data, ram_be, busy, err, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: write=%b addr=%0d data=%h be=%b busy=%b err=%b ready=%b, required all 0",
               ram_write, ram_addr, ram_data, ram_be, busy, err, cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b, required 1", cmd_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_write(input logic [6:0] x, input logic [5:0] y, input logic [7:0] t,
                            input logic [29:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
    int base;
    base = comp_addr.size();
    send(2'b00, x, y, t);
    @(negedge clk);
    checks++;
    if ({ram_write, ram_addr, ram_be, ram_data} !== {1'b1, exp_addr, exp_be, exp_data}) begin
      errors++;
      $display("FAIL write_outputs x=%0d y=%0d: write=%b addr=%0d be=%b data=%h, required 1 %0d %b %h",
               x, y, ram_write, ram_addr, ram_be, ram_data, exp_addr, exp_be, exp_data);
    end
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL write_busy: ready=%b busy=%b, required 0 1", cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if ({ram_write, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL write_return: write=%b ready=%b busy=%b, required 0 1 0", ram_write, cmd_ready, busy);
    end
    checks++;
    if (comp_addr.size() - base != 1) begin
      errors++;
      $display("FAIL write_count: completions=%0d, required 1", comp_addr.size() - base);
    end
    $display("WRITE x=%0d y=%0d tile=%h -> addr=%0d be=%b data=%h", x, y, t, exp_addr, exp_be, exp_data);
  endtask

  task automatic test_fill_all();
    int base, cycles, bad, busy_bad;
    base = comp_addr.size();
    cycles = 0; bad = 0; busy_bad = 0;
    send(2'b10, 7'd17, 6'd9, 8'h3C);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!ram_write) break;
      if (ram_addr !== 30'(cycles) || ram_data !== 32'h3C3C3C3C || ram_be !== 4'hF) bad++;
      if (!busy) busy_bad++;
      cycles++;
    end
    checks++;
    if (cycles != 1500) begin
      errors++;
      $display("FAIL fill_all_cycles: contiguous write cycles=%0d, required 1500", cycles);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_all_words: bad words=%0d, required 0", bad);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL fill_all_busy: cycles with busy low=%0d, required 0", busy_bad);
    end
    checks++;
    if ({ram_write, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL fill_all_return: write=%b ready=%b busy=%b, required 0 1 0", ram_write, cmd_ready, busy);
    end
    checks++;
    if (comp_addr.size() - base != 1500) begin
      errors++;
      $display("FAIL fill_all_count: completions=%0d, required 1500", comp_addr.size() - base);
    end
    $display("FILL_ALL tile=3c -> %0d write cycles", cycles);
  endtask

  task automatic test_fill_row_stall();
    int base, wcycles, stall_cnt, unstable, bad;
    logic stalled;
    logic [65:0] held;
    base = comp_addr.size();
    wcycles = 0; stall_cnt = 0; unstable = 0; bad = 0; stalled = 1'b0; held = '0;
    send(2'b01, 7'd33, 6'd2, 8'h07);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ram_write) break;
      wcycles++;
      if (ram_wait) begin
        if ({ram_addr, ram_data, ram_be} !== held) unstable++;
        stall_cnt++;
        if (stall_cnt == 3) ram_wait = 1'b0;
      end else if (ram_addr == 30'd60 && !stalled) begin
        stalled = 1'b1;
        held = {ram_addr, ram_data, ram_be};
        ram_wait = 1'b1;
      end
    end
    ram_wait = 1'b0;
    checks++;
    if (unstable != 0 || stall_cnt != 3) begin
      errors++;
      $display("FAIL row_stall_hold: unstable=%0d stall cycles=%0d, required 0 and 3", unstable, stall_cnt);
    end
    checks++;
    if (wcycles != 28) begin
      errors++;
      $display("FAIL row_write_cycles: write cycles=%0d, required 28", wcycles);
    end
    checks++;
    if (comp_addr.size() - base != 25) begin
      errors++;
      $display("FAIL row_count: completions=%0d, required 25", comp_addr.size() - base);
    end else begin
      for (int k = 0; k < 25; k++)
        if (comp_addr[base+k] !== 30'(50 + k) || comp_data[base+k] !== 32'h07070707 ||
            comp_be[base+k] !== 4'hF) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL row_words: bad completions=%0d, required 0", bad);
      end
    end
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL row_return: ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    $display("FILL_ROW y=2 tile=07 stall@60 -> %0d write cycles", wcycles);
  endtask

  task automatic test_error(input logic [1:0] op, input logic [6:0] x, input logic [5:0] y);
    int base;
    base = comp_addr.size();
    send(op, x, y, 8'hEE);
    @(negedge clk);
    checks++;
    if ({err, ram_write, cmd_ready, busy} !== 4'b1010) begin
      errors++;
      $display("FAIL err_pulse op=%b x=%0d y=%0d: err=%b write=%b ready=%b busy=%b, required 1 0 1 0",
               op, x, y, err, ram_write, cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if ({err, ram_write, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL err_width op=%b: err=%b write=%b ready=%b, required 0 0 1", op, err, ram_write, cmd_ready);
    end
    checks++;
    if (comp_addr.size() != base) begin
      errors++;
      $display("FAIL err_nowrite op=%b: completions=%0d, required 0", op, comp_addr.size() - base);
    end
    $display("REJECT op=%b x=%0d y=%0d", op, x, y);
  endtask

  task automatic test_reset_mid_fill();
    int base, waited;
    base = comp_addr.size();
    waited = 0;
    send(2'b10, 7'd0, 6'd0, 8'h99);
    while (comp_addr.size() - base < 10 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (comp_addr.size() - base < 10) begin
      errors++;
      $display("FAIL mid_reset_timeout: completions=%0d after %0d cycles, required 10", comp_addr.size() - base, waited);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_write, ram_addr, ram_data, ram_be, busy, err, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: write=%b addr=%0d data=%h be=%b busy=%b err=%b ready=%b, required all 0",
               ram_write, ram_addr, ram_data, ram_be, busy, err, cmd_ready);
    end
    checks++;
    if (comp_addr.size() - base != 10) begin
      errors++;
      $display("FAIL mid_reset_count: completions=%0d, required 10", comp_addr.size() - base);
    end
    rst = 1'b0;
    $display("FILL_ALL aborted by reset after 10 words");
    test_write(7'd3, 6'd1, 8'h5A, 30'd25, 4'b1000, 32'h5A000000);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write(7'd5, 6'd0, 8'hAB, 30'd1, 4'b0010, 32'h0000AB00);
    test_write(7'd99, 6'd59, 8'h11, 30'd1499, 4'b1000, 32'h11000000);
    test_fill_all();
    test_fill_row_stall();
    test_error(2'b00, 7'd100, 6'd0);
    test_error(2'b11, 7'd0, 6'd0);
    test_error(2'b01, 7'd0, 6'd60);
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
